sbox_share_ctrl: RTL
====================

Name: sbox_share_ctrl

Overview:
Time-multiplexes one shared 32-bit S-box lane (four byte S-box instances) between two requesters. The cipher-state requester needs a 128-bit SubBytes or InvSubBytes; the key-expansion requester needs a 32-bit forward SubWord. The block sits between the round datapath, the key schedule and the lane. It replaces sixteen parallel byte S-boxes with four lanes plus sequencing.

Parameters:
WORDS, 4, 32-bit words per state request; fixed at 4 for AES-128; the counter is sized from it.
KEY_FIRST, 1, tie-break winner when both requests are seen in IDLE: 1 = key, 0 = state. Used only without the round-robin macro.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
st_req  in  1  state request; level, held until st_done
st_inv  in  1  0 = forward S-box, 1 = inverse; sampled at grant
st_in  in  128  state bytes; sampled at grant
st_out  out  128  substituted state; held until the next state completion
st_done  out  1  one-cycle pulse; st_out valid
kw_req  in  1  key-word request; level, held until kw_done
kw_in  in  32  key word; sampled at grant
kw_out  out  32  SubWord result; held until the next key completion
kw_done  out  1  one-cycle pulse
lane_in  out  32  to shared lane
lane_flag  out  1  lane select: 0 = S, 1 = S-1
lane_out  in  32  combinational lane result, same cycle
busy  out  1  high when the FSM is not IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: FSM=IDLE, counter=0, st_out=0, kw_out=0, st_done=0, kw_done=0, busy=0, lane_in=0, lane_flag=0, latched data=0.
- States: IDLE, ST_RUN, KW_RUN.
- IDLE: lane_in=0, lane_flag=0.
- A requester whose done pulse is high this cycle is masked. A req still high in the cycle after done is treated as a new request.
- Grant in IDLE, on the edge ending cycle T:
  - latch data and mode;
  - go to ST_RUN (counter=0) or KW_RUN.
- ST_RUN, counter k:
  - lane_in = latched word k (word 0 = bits[31:0]); lane_flag = latched st_inv;
  - each edge writes lane_out into st_out word k;
  - k = WORDS-1: return to IDLE and set st_done for the next cycle.
- State latency: request seen at T; lane busy T+1..T+4; st_done high in T+5.
- KW_RUN (one cycle):
  - lane_in = latched kw_in; lane_flag = 0;
  - edge writes kw_out and returns to IDLE; kw_done high in T+2.
- No preemption: a kw_req arriving during ST_RUN waits. The worst-case key wait is 5 cycles.
- st_out words update progressively during ST_RUN. Consumers use st_out only on or after st_done.
- Reset mid-operation: immediate abort, all outputs return to reset values, no done pulse. A requester must re-raise req.
- Dropping req after grant: the operation still completes and emits done.
- Both dones never pulse in the same cycle.

Optional Feature:
Macro SBOX_SHARE_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register (reset value = key) gives priority to the requester not served last. KEY_FIRST is ignored.
- Undefined: fixed priority set by KEY_FIRST; no last_grant register.

Decomposition:
- Shared package aes_pkg holds:
  - FSM state enum (IDLE, ST_RUN, KW_RUN);
  - constants SBOX_FWD=1'b0 and SBOX_INV=1'b1;
  - WORD_W=32 and STATE_W=128.
- One natural sub-module: sbox_share_arb, the two-requester grant logic (fixed or round-robin, masking), kept separate so the same arbiter serves future shared resources.
- The lane itself stays outside, built from four existing byte S-box instances.

Test Plan:
1. Reset, then st_req=1, st_inv=0, st_in=128'h00112233445566778899aabbccddeeff -> lane_in=32'hccddeeff in T+1, st_done in T+5, st_out=128'h638293c31bfc33f5c4eeacea4bc12816.
2. st_inv=1, st_in=128'h638293c31bfc33f5c4eeacea4bc12816 -> st_out=128'h00112233445566778899aabbccddeeff; lane_flag=1 for 4 cycles.
3. kw_req=1, kw_in=32'h09cf4f3c -> kw_done at T+2, kw_out=32'h018a84eb, lane_flag=0.
4. st_req and kw_req raised in the same cycle:
   - without the macro, KEY_FIRST=1: kw_done at T+2, then st_done at T+7;
   - with SBOX_SHARE_RR_EN: the second back-to-back pair grants the opposite order.
5. kw_req raised during ST_RUN at count 1 -> no lane change until st_done; kw_done exactly 2 cycles after st_done.
6. rst pulsed at count 2 of ST_RUN -> st_out=0, no st_done, busy=0 asynchronously; a re-raised request completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box lane sharing FSM states, lane modes, widths.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ST_RUN,
        KW_RUN
    } share_state_t;

    localparam logic SBOX_FWD = 1'b0;
    localparam logic SBOX_INV = 1'b1;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 128;

endpackage

// File: rtl/sbox_share_arb.sv
// Two-requester grant logic with done masking.
// SBOX_SHARE_RR_EN selects round-robin instead of fixed KEY_FIRST priority.
module sbox_share_arb #(
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic st_req,
    input  logic st_mask,
    input  logic kw_req,
    input  logic kw_mask,
    output logic gnt_st,
    output logic gnt_kw
);

    logic st_v;
    logic kw_v;
    logic key_pri;

    assign st_v = st_req & ~st_mask;
    assign kw_v = kw_req & ~kw_mask;

`ifdef SBOX_SHARE_RR_EN
    // 1 = key was served last, so the state requester wins the next tie
    logic last_grant;
    localparam bit unused_key_first = KEY_FIRST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt_kw) begin
            last_grant <= 1'b1;
        end else if (gnt_st) begin
            last_grant <= 1'b0;
        end
    end

    assign key_pri = ~last_grant;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign key_pri = KEY_FIRST;
`endif

    assign gnt_kw = en & kw_v & (~st_v | key_pri);
    assign gnt_st = en & st_v & (~kw_v | ~key_pri);

endmodule

// File: rtl/sbox_share_ctrl.sv
// Time-multiplexes one 32-bit S-box lane between state and key-word requests.
// Optional SBOX_SHARE_RR_EN enables round-robin arbitration.
module sbox_share_ctrl
    import aes_pkg::*;
#(
    parameter int WORDS     = 4,
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st_req,
    input  logic                st_inv,
    input  logic [STATE_W-1:0]  st_in,
    output logic [STATE_W-1:0]  st_out,
    output logic                st_done,
    input  logic                kw_req,
    input  logic [WORD_W-1:0]   kw_in,
    output logic [WORD_W-1:0]   kw_out,
    output logic                kw_done,
    output logic [WORD_W-1:0]   lane_in,
    output logic                lane_flag,
    input  logic [WORD_W-1:0]   lane_out,
    output logic                busy
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    share_state_t       state;
    logic [CW-1:0]      cnt;
    logic [STATE_W-1:0] st_data;
    logic               st_mode;
    logic [WORD_W-1:0]  kw_data;
    logic               gnt_st;
    logic               gnt_kw;

    sbox_share_arb #(
        .KEY_FIRST (KEY_FIRST)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state == IDLE),
        .st_req  (st_req),
        .st_mask (st_done),
        .kw_req  (kw_req),
        .kw_mask (kw_done),
        .gnt_st  (gnt_st),
        .gnt_kw  (gnt_kw)
    );

    always_comb begin
        lane_in   = '0;
        lane_flag = SBOX_FWD;
        unique case (state)
            ST_RUN: begin
                lane_in   = st_data[int'(cnt)*WORD_W +: WORD_W];
                lane_flag = st_mode;
            end
            KW_RUN: lane_in = kw_data;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            st_data <= '0;
            st_mode <= SBOX_FWD;
            kw_data <= '0;
            st_out  <= '0;
            kw_out  <= '0;
            st_done <= 1'b0;
            kw_done <= 1'b0;
        end else begin
            st_done <= 1'b0;
            kw_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_st) begin
                        st_data <= st_in;
                        st_mode <= st_inv;
                        cnt     <= '0;
                        state   <= ST_RUN;
                    end else if (gnt_kw) begin
                        kw_data <= kw_in;
                        state   <= KW_RUN;
                    end
                end
                ST_RUN: begin
                    st_out[int'(cnt)*WORD_W +: WORD_W] <= lane_out;
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        st_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                KW_RUN: begin
                    kw_out  <= lane_out;
                    kw_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
